pc_ras: RTL and testbench

- Parametrised program counter with an integrated return-address stack (RAS) for the glorbcore fetch stage.
- Holds the current instruction-memory address and advances it by a fixed step each cycle. Supports stall, taken branch, call (jump and push return address) and return (pop and jump).
- The PC is a registered output, with a defined synchronous reset vector.

---
 rtl/pc_ras_if.sv | 28 ++
 rtl/pc_ras.sv | 92 +++++++++
 tb/tb_pc_ras.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pc_ras_if.sv
// Fetch-stage control/status bundle between the sequencer and the PC/return-address stack.
// master drives redirects and observes PC/stack status; slave is the pc_ras block itself.
interface pc_ras_if #(
    parameter int unsigned IMW       = 4,
    parameter int unsigned RAS_DEPTH = 4
);
    logic                             stall;
    logic                             branch_taken;
    logic                             call;
    logic                             ret;
    logic [IMW-1:0]                   branch_target;
    logic [IMW-1:0]                   pc_out;
    logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count;
    logic                             ras_full;
    logic                             ras_empty;
    logic                             ras_overflow;
    logic                             ras_underflow;

    modport master (
        output stall, branch_taken, call, ret, branch_target,
        input  pc_out, ras_count, ras_full, ras_empty, ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, branch_taken, call, ret, branch_target,
        output pc_out, ras_count, ras_full, ras_empty, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_ras.sv
// Program counter with a circular return-address stack for the glorbcore fetch stage.
// Priority each edge: start > stall > ret > call > branch_taken > sequential step.
module pc_ras #(
    parameter int unsigned    IMW       = 4,
    parameter int unsigned    RAS_DEPTH = 4,
    parameter logic [IMW-1:0] RESET_VEC = '0,
    parameter int unsigned    STEP      = 1
) (
    input logic     clk,
    input logic     start,
    pc_ras_if.slave bus
);
    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH+1);

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_POP,
        OP_UNDERFLOW,
        OP_PUSH,
        OP_BRANCH,
        OP_SEQ
    } op_t;

    logic [IMW-1:0] stack [RAS_DEPTH];
    logic [PW-1:0]  top_q;
    logic [PW-1:0]  top_inc;
    logic [CW-1:0]  count_q;
    logic [IMW-1:0] pc_q;
    logic [IMW-1:0] seq_pc;
    logic           ovf_q;
    logic           unf_q;
    logic           full;
    logic           empty;
    op_t            op;

    assign seq_pc  = pc_q + IMW'(STEP);
    assign top_inc = top_q + PW'(1);
    assign full    = (count_q == CW'(RAS_DEPTH));
    assign empty   = (count_q == '0);

    always_comb begin
        op = OP_SEQ;
        if (bus.stall)             op = OP_HOLD;
        else if (bus.ret)          op = empty ? OP_UNDERFLOW : OP_POP;
        else if (bus.call)         op = OP_PUSH;
        else if (bus.branch_taken) op = OP_BRANCH;
    end

    always_ff @(posedge clk) begin
        if (start) begin
            pc_q    <= RESET_VEC;
            top_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            case (op)
                OP_HOLD: ;
                OP_POP: begin
                    pc_q    <= stack[top_q];
                    top_q   <= top_q - PW'(1);
                    count_q <= count_q - CW'(1);
                end
                OP_UNDERFLOW: begin
                    pc_q  <= seq_pc;
                    unf_q <= 1'b1;
                end
                OP_PUSH: begin
                    // A full stack keeps advancing the pointer, silently dropping the oldest entry.
                    pc_q  <= bus.branch_target;
                    top_q <= top_inc;
                    if (full) ovf_q   <= 1'b1;
                    else      count_q <= count_q + CW'(1);
                end
                OP_BRANCH: pc_q <= bus.branch_target;
                default:   pc_q <= seq_pc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!start && op == OP_PUSH) stack[top_inc] <= seq_pc;
    end

    assign bus.pc_out        = pc_q;
    assign bus.ras_count     = count_q;
    assign bus.ras_full      = full;
    assign bus.ras_empty     = empty;
    assign bus.ras_overflow  = ovf_q;
    assign bus.ras_underflow = unf_q;
endmodule

// File: tb/tb_pc_ras.sv
// Directed bench for pc_ras (IMW=4, RAS_DEPTH=4, RESET_VEC=3, STEP=1) with hand-computed expectations.
module tb_pc_ras;
    logic clk = 1'b0;
    logic start;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    pc_ras_if #(.IMW(4), .RAS_DEPTH(4)) bus ();

    pc_ras #(
        .IMW      (4),
        .RAS_DEPTH(4),
        .RESET_VEC(4'd3),
        .STEP     (1)
    ) dut (
        .clk  (clk),
        .start(start),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        start             = 1'b0;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.call          = 1'b0;
        bus.ret           = 1'b0;
        bus.branch_target = '0;
    endtask

    task automatic state(input string tag, input int pc, input int cnt);
        check({tag, ".pc"}, 32'(bus.pc_out), 32'(pc));
        check({tag, ".cnt"}, 32'(bus.ras_count), 32'(cnt));
    endtask

    task automatic do_call(input logic [3:0] tgt);
        idle();
        bus.call = 1'b1;
        bus.branch_target = tgt;
        tick();
        idle();
    endtask

    task automatic do_ret();
        idle();
        bus.ret = 1'b1;
        tick();
        idle();
    endtask

    task automatic do_branch(input logic [3:0] tgt);
        idle();
        bus.branch_taken = 1'b1;
        bus.branch_target = tgt;
        tick();
        idle();
    endtask

    initial begin
        idle();
        start = 1'b1;
        tick();
        start = 1'b0;
        state("reset", 3, 0);
        check("reset.empty", 32'(bus.ras_empty), 1);
        check("reset.full", 32'(bus.ras_full), 0);
        check("reset.ovf", 32'(bus.ras_overflow), 0);
        check("reset.unf", 32'(bus.ras_underflow), 0);

        // sequential advance with modulo wrap: 4..15, 0, 1
        for (int i = 1; i <= 14; i++) begin
            tick();
            check("seq.pc", 32'(bus.pc_out), 32'((3 + i) % 16));
            check("seq.empty", 32'(bus.ras_empty), 1);
        end

        // stall and branch
        for (int i = 0; i < 4; i++) tick();
        check("pre_stall.pc", 32'(bus.pc_out), 5);
        bus.stall = 1'b1;
        tick(); check("stall1.pc", 32'(bus.pc_out), 5);
        tick(); check("stall2.pc", 32'(bus.pc_out), 5);
        do_branch(4'd9); check("branch.pc", 32'(bus.pc_out), 9);
        tick();          check("after_branch.pc", 32'(bus.pc_out), 10);

        // single call/return
        do_branch(4'd2);
        do_call(4'd8);  state("call1", 8, 1);
        check("call1.empty", 32'(bus.ras_empty), 0);
        tick(); tick(); check("adv.pc", 32'(bus.pc_out), 10);
        do_ret();       state("ret1", 3, 0);
        check("ret1.empty", 32'(bus.ras_empty), 1);

        // nested calls return in LIFO order
        do_call(4'd8);  state("ncall1", 8, 1);
        do_call(4'd12); state("ncall2", 12, 2);
        do_ret();       state("nret1", 9, 1);
        do_ret();       state("nret2", 4, 0);

        // overflow: pushes 1,5,9,13 then 2 overwrites the oldest
        do_branch(4'd0);
        do_call(4'd4);  state("ov1", 4, 1);
        do_call(4'd8);  state("ov2", 8, 2);
        do_call(4'd12); state("ov3", 12, 3);
        do_call(4'd0);  state("ov4", 0, 4);
        check("ov4.full", 32'(bus.ras_full), 1);
        check("ov4.ovf", 32'(bus.ras_overflow), 0);
        tick();         check("ov.adv", 32'(bus.pc_out), 1);
        do_call(4'd5);  state("ov5", 5, 4);
        check("ov5.ovf", 32'(bus.ras_overflow), 1);
        check("ov5.full", 32'(bus.ras_full), 1);
        do_ret(); state("oret1", 2, 3);
        do_ret(); state("oret2", 13, 2);
        do_ret(); state("oret3", 9, 1);
        do_ret(); state("oret4", 5, 0);
        check("oret4.unf", 32'(bus.ras_underflow), 0);
        do_ret(); state("oret5", 6, 0);
        check("oret5.unf", 32'(bus.ras_underflow), 1);
        check("oret5.ovf", 32'(bus.ras_overflow), 1);

        // call+ret together: pop wins, no push
        do_call(4'd10); state("sim.c1", 10, 1);
        do_call(4'd12); state("sim.c2", 12, 2);
        bus.call = 1'b1; bus.ret = 1'b1; bus.branch_target = 4'd0;
        tick(); idle(); state("callret", 11, 1);
        do_ret();       state("callret.ret", 7, 0);

        // stall+ret holds everything
        do_call(4'd9);  state("sr.call", 9, 1);
        bus.stall = 1'b1; bus.ret = 1'b1;
        tick(); idle(); state("stallret", 9, 1);
        do_ret();       state("sr.ret", 8, 0);

        // start together with call
        start = 1'b1; bus.call = 1'b1; bus.branch_target = 4'd12;
        tick(); idle(); state("startcall", 3, 0);
        check("startcall.ovf", 32'(bus.ras_overflow), 0);
        check("startcall.unf", 32'(bus.ras_underflow), 0);

        // mid-operation reset with 3 entries and both sticky flags set
        do_ret(); state("mid.unf", 4, 0);
        for (int i = 0; i < 5; i++) do_call(4'd0);
        do_ret(); state("mid.pop", 1, 3);
        check("mid.ovf", 32'(bus.ras_overflow), 1);
        check("mid.unf_flag", 32'(bus.ras_underflow), 1);
        start = 1'b1;
        tick(); idle(); state("midreset", 3, 0);
        check("midreset.ovf", 32'(bus.ras_overflow), 0);
        check("midreset.unf", 32'(bus.ras_underflow), 0);
        check("midreset.empty", 32'(bus.ras_empty), 1);
        do_ret(); state("post.ret", 4, 0);
        check("post.unf", 32'(bus.ras_underflow), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
